// File: rtl/video_timing_pkg.sv
// Shared timing presets, decode struct and packing helpers for the video
// timing family (fetch/unpack front end and future timing-only blocks).
package video_timing_pkg;

    // Counter width; every frame dimension must fit below 2**CNT_W.
    localparam int CNT_W = 12;

    typedef struct packed {
        int res_x;
        int h_front;
        int h_pulse;
        int h_back;
        int res_y;
        int v_front;
        int v_pulse;
        int v_back;
        int h_pol;
        int v_pol;
    } timing_preset_t;

    localparam timing_preset_t TIMING_640X480_60 = '{
        res_x: 640, h_front: 16, h_pulse: 96,  h_back: 48,
        res_y: 480, v_front: 10, v_pulse: 2,   v_back: 33,
        h_pol: 0,   v_pol: 0
    };

    localparam timing_preset_t TIMING_800X600_60 = '{
        res_x: 800, h_front: 40, h_pulse: 128, h_back: 88,
        res_y: 600, v_front: 1,  v_pulse: 4,   v_back: 23,
        h_pol: 1,   v_pol: 1
    };

    // Per-clock decode of the raster position.
    typedef struct packed {
        logic fetch_area;
        logic visible_line;
        logic hsync_act;
        logic vsync_act;
    } sync_decode_t;

    function automatic int ppw_of(input int word_bits, input int bpp);
        return word_bits / bpp;
    endfunction

    function automatic int span_of(input int word_bits, input int bpp, input int dbl_x);
        return ppw_of(word_bits, bpp) * (1 + dbl_x);
    endfunction

    function automatic bit bpp_legal(input int bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8) || (bpp == 16);
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Raster position counters (cx/cy) with visible-area and sync-window decode.
// Frame size is the sum of the visible area and the three porch/pulse terms.
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int resolution_x      = 640,
    parameter int hsync_front_porch = 16,
    parameter int hsync_pulse       = 96,
    parameter int hsync_back_porch  = 48,
    parameter int resolution_y      = 480,
    parameter int vsync_front_porch = 10,
    parameter int vsync_pulse       = 2,
    parameter int vsync_back_porch  = 33
) (
    input  logic             clk_pixel,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output sync_decode_t     decode
);

    localparam int frame_x = resolution_x + hsync_front_porch + hsync_pulse + hsync_back_porch;
    localparam int frame_y = resolution_y + vsync_front_porch + vsync_pulse + vsync_back_porch;

    localparam logic [CNT_W-1:0] cx_last  = CNT_W'(frame_x - 1);
    localparam logic [CNT_W-1:0] cy_last  = CNT_W'(frame_y - 1);
    localparam logic [CNT_W-1:0] res_x_c  = CNT_W'(resolution_x);
    localparam logic [CNT_W-1:0] res_y_c  = CNT_W'(resolution_y);
    localparam logic [CNT_W-1:0] hs_start = CNT_W'(resolution_x + hsync_front_porch);
    localparam logic [CNT_W-1:0] hs_end   = CNT_W'(resolution_x + hsync_front_porch + hsync_pulse);
    localparam logic [CNT_W-1:0] vs_start = CNT_W'(resolution_y + vsync_front_porch);
    localparam logic [CNT_W-1:0] vs_end   = CNT_W'(resolution_y + vsync_front_porch + vsync_pulse);

    if (frame_x >= (1 << CNT_W) || frame_y >= (1 << CNT_W)) begin : g_bad_frame
        $error("video_sync_counter: frame dimensions exceed counter width");
    end

    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;

    always_comb begin
        cx_d = cx_q + CNT_W'(1);
        cy_d = cy_q;
        if (cx_q == cx_last) begin
            cx_d = '0;
            cy_d = (cy_q == cy_last) ? '0 : cy_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    always_comb begin
        decode.visible_line = (cy_q < res_y_c);
        decode.fetch_area   = (cx_q < res_x_c) && (cy_q < res_y_c);
        decode.hsync_act    = (cx_q >= hs_start) && (cx_q < hs_end);
        decode.vsync_act    = (cy_q >= vs_start) && (cy_q < vs_end);
    end

    assign cx = cx_q;
    assign cy = cy_q;

endmodule

// File: rtl/video_fetch_timing.sv
// Video timing generator and packed-word pixel unpacker: fetch strobe, shift
// register, underrun flag and the registered, mutually aligned video outputs.
module video_fetch_timing
    import video_timing_pkg::*;
#(
    parameter int resolution_x      = TIMING_640X480_60.res_x,
    parameter int hsync_front_porch = TIMING_640X480_60.h_front,
    parameter int hsync_pulse       = TIMING_640X480_60.h_pulse,
    parameter int hsync_back_porch  = TIMING_640X480_60.h_back,
    parameter int resolution_y      = TIMING_640X480_60.res_y,
    parameter int vsync_front_porch = TIMING_640X480_60.v_front,
    parameter int vsync_pulse       = TIMING_640X480_60.v_pulse,
    parameter int vsync_back_porch  = TIMING_640X480_60.v_back,
    parameter int hsync_polarity    = TIMING_640X480_60.h_pol,
    parameter int vsync_polarity    = TIMING_640X480_60.v_pol,
    parameter int word_bits         = 32,
    parameter int bpp               = 4,
    parameter int dbl_x             = 0,
    parameter int dbl_y             = 0
) (
    input  logic                 clk_pixel,
    input  logic                 rst_n,
    input  logic [word_bits-1:0] word_data,
    input  logic                 word_valid,
    output logic                 fetch_next,
    output logic                 line_repeat,
    output logic                 frame_start,
    input  logic                 underrun_clr,
    output logic                 underrun,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_de,
    output logic [bpp-1:0]       pixel
);

    localparam int span = span_of(word_bits, bpp, dbl_x);
    localparam logic [CNT_W-1:0] span_c = CNT_W'(span);
    localparam logic hs_on = 1'(hsync_polarity);
    localparam logic vs_on = 1'(vsync_polarity);

    if (!bpp_legal(bpp) || (word_bits % bpp) != 0 || (resolution_x % span) != 0) begin : g_bad_cfg
        $error("video_fetch_timing: illegal bpp / word_bits / resolution_x combination");
    end

    logic [CNT_W-1:0] cx, cy;
    sync_decode_t     dec;

    video_sync_counter #(
        .resolution_x      (resolution_x),
        .hsync_front_porch (hsync_front_porch),
        .hsync_pulse       (hsync_pulse),
        .hsync_back_porch  (hsync_back_porch),
        .resolution_y      (resolution_y),
        .vsync_front_porch (vsync_front_porch),
        .vsync_pulse       (vsync_pulse),
        .vsync_back_porch  (vsync_back_porch)
    ) u_sync_counter (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .cx        (cx),
        .cy        (cy),
        .decode    (dec)
    );

    logic                 fetch_raw;
    logic                 shift_en;
    logic [word_bits-1:0] sr_q, sr_d;
    logic [bpp-1:0]       pixel_q, pixel_d;
    logic                 vga_de_q, vga_de_d;
    logic                 vga_hsync_q, vga_hsync_d;
    logic                 vga_vsync_q, vga_vsync_d;
    logic                 frame_start_q, frame_start_d;
    logic                 line_repeat_q, line_repeat_d;
    logic                 underrun_q, underrun_d;

    assign fetch_raw  = dec.fetch_area && ((cx % span_c) == '0);
    assign fetch_next = fetch_raw && rst_n;

    // A doubled pixel advances on the even clock that follows its odd (second) clock.
    assign shift_en = dec.fetch_area && !fetch_raw && ((dbl_x == 0) || !cx[0]);

    always_comb begin
        sr_d = sr_q;
        if (fetch_raw) begin
            sr_d = word_valid ? word_data : '0;
        end else if (shift_en) begin
            sr_d = sr_q >> bpp;
        end
    end

    always_comb begin
        pixel_d       = dec.fetch_area ? sr_d[bpp-1:0] : '0;
        vga_de_d      = dec.fetch_area;
        vga_hsync_d   = dec.hsync_act ? hs_on : ~hs_on;
        vga_vsync_d   = dec.vsync_act ? vs_on : ~vs_on;
        frame_start_d = dec.fetch_area && (cx == '0) && (cy == '0);
        line_repeat_d = (dbl_y != 0) && dec.hsync_act && !cy[0] && dec.visible_line;
        // A new underrun wins over a clear arriving on the same clock.
        underrun_d    = (fetch_raw && !word_valid) || (underrun_q && !underrun_clr);
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            sr_q          <= '0;
            pixel_q       <= '0;
            vga_de_q      <= 1'b0;
            vga_hsync_q   <= ~hs_on;
            vga_vsync_q   <= ~vs_on;
            frame_start_q <= 1'b0;
            line_repeat_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            pixel_q       <= pixel_d;
            vga_de_q      <= vga_de_d;
            vga_hsync_q   <= vga_hsync_d;
            vga_vsync_q   <= vga_vsync_d;
            frame_start_q <= frame_start_d;
            line_repeat_q <= line_repeat_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pixel       = pixel_q;
    assign vga_de      = vga_de_q;
    assign vga_hsync   = vga_hsync_q;
    assign vga_vsync   = vga_vsync_q;
    assign frame_start = frame_start_q;
    assign line_repeat = line_repeat_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_video_fetch_timing.sv
// Directed bench: a small-raster 4bpp instance, a small-raster doubled 8bpp
// instance and a default 640x480 instance share one clock and reset.
module tb_video_fetch_timing;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // Small raster: 16+2+3+3 = 24 clocks/line, 4+1+1+1 = 7 lines.
    localparam int FX = 24;
    localparam int FY = 7;

    logic [31:0] word_a, word_b, word_d;
    logic        valid_a, valid_b, valid_d;
    logic        clr_a, clr_b, clr_d;
    logic        fetch_a, fetch_b, fetch_d;
    logic        lr_a, lr_b, lr_d;
    logic        fs_a, fs_b, fs_d;
    logic        ur_a, ur_b, ur_d;
    logic        hs_a, hs_b, hs_d;
    logic        vs_a, vs_b, vs_d;
    logic        de_a, de_b, de_d;
    logic [3:0]  pix_a;
    logic [7:0]  pix_b;
    logic [3:0]  pix_d;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    video_fetch_timing #(
        .resolution_x(16), .hsync_front_porch(2), .hsync_pulse(3), .hsync_back_porch(3),
        .resolution_y(4), .vsync_front_porch(1), .vsync_pulse(1), .vsync_back_porch(1),
        .hsync_polarity(1), .vsync_polarity(0), .word_bits(32), .bpp(4), .dbl_x(0), .dbl_y(0)
    ) u_a (
        .clk_pixel(clk), .rst_n(rst_n), .word_data(word_a), .word_valid(valid_a),
        .fetch_next(fetch_a), .line_repeat(lr_a), .frame_start(fs_a), .underrun_clr(clr_a),
        .underrun(ur_a), .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_de(de_a), .pixel(pix_a)
    );

    video_fetch_timing #(
        .resolution_x(16), .hsync_front_porch(2), .hsync_pulse(3), .hsync_back_porch(3),
        .resolution_y(4), .vsync_front_porch(1), .vsync_pulse(1), .vsync_back_porch(1),
        .hsync_polarity(0), .vsync_polarity(0), .word_bits(32), .bpp(8), .dbl_x(1), .dbl_y(1)
    ) u_b (
        .clk_pixel(clk), .rst_n(rst_n), .word_data(word_b), .word_valid(valid_b),
        .fetch_next(fetch_b), .line_repeat(lr_b), .frame_start(fs_b), .underrun_clr(clr_b),
        .underrun(ur_b), .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_de(de_b), .pixel(pix_b)
    );

    video_fetch_timing u_d (
        .clk_pixel(clk), .rst_n(rst_n), .word_data(word_d), .word_valid(valid_d),
        .fetch_next(fetch_d), .line_repeat(lr_d), .frame_start(fs_d), .underrun_clr(clr_d),
        .underrun(ur_d), .vga_hsync(hs_d), .vga_vsync(vs_d), .vga_de(de_d), .pixel(pix_d)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks; every sample point sits 1 time unit after a falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic advance_to(input int from_t, input int to_t);
        for (int k = from_t; k < to_t; k++) tick();
    endtask

    initial begin
        int fa, fb, fs_cnt, fs_first, hs_cnt, hs_first, vs_cnt, vs_first, de_cnt;
        int idle_px, lr_cnt, lr_odd, lra_cnt, ur_seen;
        int fd, hsd_cnt, hsd_first, fsd_cnt, ded_cnt, line;
        logic [15:0] e;
        logic [7:0]  pat_b[8];

        rst_n   = 1'b0;
        word_a  = 32'h7654_3210;
        word_b  = 32'h4433_2211;
        word_d  = 32'h7654_3210;
        valid_a = 1'b1; valid_b = 1'b1; valid_d = 1'b1;
        clr_a   = 1'b0; clr_b   = 1'b0; clr_d   = 1'b0;
        pat_b   = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

        // Scoreboard: expected visible pixels of the first frame of u_a and u_b.
        for (int ln = 0; ln < 4; ln++) begin
            for (int p = 0; p < 16; p++) begin
                exp_q_a.push_back(16'(p % 8));
                exp_q_b.push_back(16'(pat_b[p % 8]));
            end
        end

        repeat (3) @(negedge clk);
        #1;
        check("rst_de_a", de_a, 0);
        check("rst_pix_a", pix_a, 0);
        check("rst_fs_a", fs_a, 0);
        check("rst_ur_a", ur_a, 0);
        check("rst_hs_a_pol1", hs_a, 0);
        check("rst_vs_a", vs_a, 1);
        check("rst_fetch_a", fetch_a, 0);
        check("rst_lr_b", lr_b, 0);
        check("rst_hs_d", hs_d, 1);
        check("rst_vs_d", vs_d, 1);

        fa = 0; fb = 0; fs_cnt = 0; fs_first = -1; hs_cnt = 0; hs_first = -1;
        vs_cnt = 0; vs_first = -1; de_cnt = 0; idle_px = 0; lr_cnt = 0; lr_odd = 0;
        lra_cnt = 0; ur_seen = 0; fd = 0; hsd_cnt = 0; hsd_first = -1; fsd_cnt = 0; ded_cnt = 0;

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("fetch_first_clk", fetch_a, 1);
        for (int t = 0; t < 800; t++) begin
            if (t < FX * FY) begin
                if (fetch_a) fa++;
                if (fetch_b) fb++;
            end
            if (t >= 1 && t <= FX * FY) begin
                line = ((t - 1) / FX) % FY;
                if (fs_a) begin
                    fs_cnt++;
                    if (fs_first < 0) fs_first = t;
                end
                if (hs_a) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = t;
                end
                if (!vs_a) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = t;
                end
                if (de_a) begin
                    de_cnt++;
                    e = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 16'hdead;
                    check("pix_a", 32'(pix_a), 32'(e));
                end else if (pix_a != 0) begin
                    idle_px++;
                end
                if (de_b) begin
                    e = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 16'hdead;
                    check("pix_b_dblx", 32'(pix_b), 32'(e));
                end else if (pix_b != 0) begin
                    idle_px++;
                end
                if (lr_b) begin
                    lr_cnt++;
                    if (line % 2 == 1) lr_odd++;
                end
                if (lr_a) lra_cnt++;
                if (ur_a) ur_seen++;
            end
            if (fetch_d) fd++;
            if (t >= 1) begin
                if (!hs_d) begin
                    hsd_cnt++;
                    if (hsd_first < 0) hsd_first = t;
                end
                if (fs_d) fsd_cnt++;
                if (de_d) ded_cnt++;
            end
            tick();
        end

        check("fetch_cnt_a", fa, 8);
        check("fetch_cnt_b_dblx", fb, 8);
        check("fs_cnt_a", fs_cnt, 1);
        check("fs_first_a", fs_first, 1);
        check("hs_cnt_a", hs_cnt, 21);
        check("hs_first_a", hs_first, 19);
        check("vs_cnt_a", vs_cnt, 24);
        check("vs_first_a", vs_first, 121);
        check("de_cnt_a", de_cnt, 64);
        check("pix_idle_zero", idle_px, 0);
        check("exp_q_a_empty", exp_q_a.size(), 0);
        check("exp_q_b_empty", exp_q_b.size(), 0);
        check("lr_cnt_b", lr_cnt, 6);
        check("lr_odd_b", lr_odd, 0);
        check("lr_a_tied0", lra_cnt, 0);
        check("ur_a_none", ur_seen, 0);
        check("fetch_cnt_d_line", fd, 80);
        check("hs_low_cnt_d", hsd_cnt, 96);
        check("hs_low_first_d", hsd_first, 657);
        check("fs_cnt_d", fsd_cnt, 1);
        check("de_cnt_d_line", ded_cnt, 640);

        // Underrun on the word fetched at cx=8, then clear handling.
        reset_dut();
        for (int t = 0; t < 32; t++) begin
            if (t == 8) begin
                check("ur_pre", ur_a, 0);
                check("fetch_cx8", fetch_a, 1);
                valid_a = 1'b0;
            end
            if (t == 9) begin
                valid_a = 1'b1;
                check("ur_set", ur_a, 1);
            end
            if (t >= 1 && t <= 8) check("pix_before_ur", pix_a, 4'(t - 1));
            if (t >= 9 && t <= 16) check("pix_ur_zero", pix_a, 0);
            if (t == 20) check("ur_sticky", ur_a, 1);
            if (t == 24) begin
                check("fetch_line1", fetch_a, 1);
                valid_a = 1'b0;
                clr_a   = 1'b1;
            end
            if (t == 25) begin
                valid_a = 1'b1;
                clr_a   = 1'b0;
                check("ur_set_beats_clr", ur_a, 1);
            end
            if (t == 30) clr_a = 1'b1;
            if (t == 31) begin
                clr_a = 1'b0;
                check("ur_clr", ur_a, 0);
            end
            tick();
        end

        // Reset asserted mid-frame at cx=10, cy=2 with an underrun pending.
        reset_dut();
        for (int t = 0; t < 58; t++) begin
            if (t == 8) valid_a = 1'b0;
            if (t == 9) valid_a = 1'b1;
            tick();
        end
        check("mid_de_a", de_a, 1);
        check("mid_pix_a", pix_a, 1);
        check("mid_ur_a", ur_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_de_a", de_a, 0);
        check("async_pix_a", pix_a, 0);
        check("async_ur_a", ur_a, 0);
        check("async_fetch_a", fetch_a, 0);
        check("async_hs_a", hs_a, 0);
        check("async_de_b", de_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_fetch_a", fetch_a, 1);
        tick();
        check("rel_fs_a", fs_a, 1);
        check("rel_de_a", de_a, 1);
        check("rel_pix_a", pix_a, 0);
        check("rel_hs_a_pol1", hs_a, 0);
        check("rel_fetch_a_off", fetch_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
